// File: rtl/chacha_pkg.sv
// chacha_pkg: shared quarter-round FSM states, rotation amounts and rotate helper
package chacha_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} qr_state_e;
  localparam logic [4:0] ROT_0 = 5'd16;
  localparam logic [4:0] ROT_1 = 5'd12;
  localparam logic [4:0] ROT_2 = 5'd8;
  localparam logic [4:0] ROT_3 = 5'd7;
  function automatic logic [31:0] rotl32(input logic [31:0] x, input logic [4:0] r);
    logic [63:0] t;
    t = {x, x} << r;
    return t[63:32];
  endfunction
endpackage

// File: rtl/chacha_qr_step.sv
// chacha_qr_step: one add-xor-rotate half step, x = x + y; z = (z ^ x) <<< r
module chacha_qr_step
  import chacha_pkg::*;
(
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic [31:0] z_i,
  input  logic [4:0]  r_i,
  output logic [31:0] x_o,
  output logic [31:0] z_o
);
  assign x_o = x_i + y_i;
  assign z_o = rotl32(z_i ^ x_o, r_i);
endmodule

// File: rtl/chacha_qr_unit.sv
// chacha_qr_unit: four-cycle sequential ChaCha quarter-round over a shared step unit
module chacha_qr_unit
  import chacha_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [31:0] c_in,
  input  logic [31:0] d_in,
  output logic [31:0] a_out,
  output logic [31:0] b_out,
  output logic [31:0] c_out,
  output logic [31:0] d_out,
  output logic        busy,
  output logic        done
);
  qr_state_e   state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] a_q, b_q, c_q, d_q;
  logic [31:0] a_d, b_d, c_d, d_d;
  logic [31:0] x, y, z, x_n, z_n;
  logic [4:0]  r;
  logic        load;

  assign load = start && state_q != RUN;
  assign x = step_q[0] ? c_q : a_q;
  assign y = step_q[0] ? d_q : b_q;
  assign z = step_q[0] ? b_q : d_q;
  assign r = step_q == 2'd0 ? ROT_0 : step_q == 2'd1 ? ROT_1 : step_q == 2'd2 ? ROT_2 : ROT_3;

  chacha_qr_step u_step (
    .x_i(x),
    .y_i(y),
    .z_i(z),
    .r_i(r),
    .x_o(x_n),
    .z_o(z_n)
  );

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  end

  // next state: load from IDLE/DONE, leave RUN after the fourth step, otherwise settle in IDLE
  always_comb begin
    state_d = load ? RUN : state_q == RUN ? (step_q == 2'd3 ? DONE : RUN) : IDLE;
  end

  // status outputs decoded from the state alone
  always_comb begin
    busy = state_q == RUN;
    done = state_q == DONE;
  end

  // working-register next values: load operands or apply the step picked by the counter
  always_comb begin
    a_d = a_q;
    b_d = b_q;
    c_d = c_q;
    d_d = d_q;
    step_d = step_q;
    if (load) begin
      a_d = a_in;
      b_d = b_in;
      c_d = c_in;
      d_d = d_in;
      step_d = 2'd0;
    end else if (state_q == RUN) begin
      step_d = step_q + 2'd1;
      if (step_q[0]) begin
        c_d = x_n;
        b_d = z_n;
      end else begin
        a_d = x_n;
        d_d = z_n;
      end
    end
  end

  // working registers and step counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
      d_q <= '0;
      step_q <= '0;
    end else begin
      a_q <= a_d;
      b_q <= b_d;
      c_q <= c_d;
      d_q <= d_d;
      step_q <= step_d;
    end
  end

  assign a_out = a_q;
  assign b_out = b_q;
  assign c_out = c_q;
  assign d_out = d_q;
endmodule

// File: tb/tb_chacha_qr_unit.sv
// tb_chacha_qr_unit: randomized scoreboard bench for the quarter-round unit
module tb_chacha_qr_unit;
  logic        clk = 1'b0;
  logic        rst_n, start;
  logic [31:0] a_in, b_in, c_in, d_in;
  logic [31:0] a_out, b_out, c_out, d_out;
  logic        busy, done;
  logic [127:0] exp_q[$];
  int n_chk = 0, n_fail = 0, done_cnt = 0;

  chacha_qr_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .a_out(a_out), .b_out(b_out), .c_out(c_out), .d_out(d_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rol(input logic [31:0] v, input int s);
    return (v << s) | (v >> (32 - s));
  endfunction

  function automatic logic [127:0] qr_ref(input logic [31:0] a, b, c, d);
    a = a + b; d = rol(d ^ a, 16);
    c = c + d; b = rol(b ^ c, 12);
    a = a + b; d = rol(d ^ a, 8);
    c = c + d; b = rol(b ^ c, 7);
    return {a, b, c, d};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic launch(input logic [31:0] a, b, c, d, input bit push, input logic [127:0] exp);
    a_in = a; b_in = b; c_in = c; d_in = d;
    start = 1'b1;
    if (push) exp_q.push_back(exp);
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  // monitor: pop expected result on every done, and watch busy/done exclusivity
  always @(negedge clk) begin
    check("busy_done_excl", 128'(busy & done), 128'd0);
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) check("unexpected_done", 128'd1, 128'd0);
      else check("result", {a_out, b_out, c_out, d_out}, exp_q.pop_front());
    end
  end

  initial begin
    int n, d0;
    logic [31:0] ra, rb, rc, rd;
    rst_n = 1'b0; start = 1'b0;
    a_in = '0; b_in = '0; c_in = '0; d_in = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {a_out, b_out, c_out, d_out}, 128'd0);
    check("reset_status", 128'({busy, done}), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    launch(32'h11111111, 32'h01020304, 32'h9b8d6f43, 32'h01234567, 1'b1,
           {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb});
    @(negedge clk); start = 1'b0;
    check("rfc_busy", 128'(busy), 128'd1);
    wait_done(n);
    check("rfc_latency", 128'(n), 128'd5);
    @(negedge clk);
    check("idle_hold", {a_out, b_out, c_out, d_out},
          {32'hea2a92f4, 32'hcb1cf8ce, 32'h4581472e, 32'h5881c4bb});
    check("idle_status", 128'({busy, done}), 128'd0);

    launch('1, '1, '1, '1, 1'b1, qr_ref('1, '1, '1, '1));
    @(negedge clk); start = 1'b0;
    wait_done(n);
    check("ovf_latency", 128'(n), 128'd5);
    @(negedge clk);

    ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
    d0 = done_cnt;
    launch(ra, rb, rc, rd, 1'b1, qr_ref(ra, rb, rc, rd));
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      launch($urandom, $urandom, $urandom, $urandom, 1'b0, '0);
    end
    @(negedge clk);
    check("run_start_done", 128'(done), 128'd1);
    start = 1'b0;
    repeat (8) @(negedge clk);
    check("run_start_one_done", 128'(done_cnt - d0), 128'd1);

    launch($urandom, $urandom, $urandom, $urandom, 1'b0, '0);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_status", 128'({busy, done}), 128'd0);
    check("abort_outputs", {a_out, b_out, c_out, d_out}, 128'd0);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (8) @(negedge clk);
    check("abort_no_done", 128'(done_cnt - d0), 128'd0);

    ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
    launch(ra, rb, rc, rd, 1'b1, qr_ref(ra, rb, rc, rd));
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      wait_done(n);
      check("b2b_latency", 128'(n), 128'd5);
      if (i < 999) begin
        ra = $urandom; rb = $urandom; rc = $urandom; rd = $urandom;
        launch(ra, rb, rc, rd, 1'b1, qr_ref(ra, rb, rc, rd));
      end
      @(negedge clk); start = 1'b0;
    end
    repeat (5) @(negedge clk);
    check("queue_empty", 128'(exp_q.size()), 128'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
